store_buffer: RTL
=================

# store_buffer

Posted-store buffer between the EX/MEM pipeline register and the data memory. Accepts SB/SH/SW stores in one cycle and drains them in order into the single memory port whenever no load needs that port. Loads pass straight through to memory with zero added latency. A load that overlaps a buffered store stalls until the conflicting entry has drained, or is forwarded when forwarding is compiled in.

## Interface
- DEPTH, 4: number of buffered stores; power of two, 2..16.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- st_valid_in  in  1  store request from MEM stage.
- st_addr_in  in  32  store byte address.
- st_data_in  in  32  store data, right-aligned (byte/half in low bits).
- st_func3_in  in  3  000 SB, 001 SH, 010 SW.
- st_ready_out  out  1  buffer can accept a store this cycle.
- st_misalign_out  out  1  store rejected: misaligned, or func3 not in {000,001,010}.
- ld_valid_in  in  1  load request from MEM stage.
- ld_addr_in  in  32  load byte address.
- ld_func3_in  in  3  load width/sign (000/001/010/100/101).
- ld_stall_out  out  1  load must be held by the pipeline this cycle.
- ld_fwd_valid_out  out  1  load data supplied by the buffer (always 0 without forwarding).
- ld_fwd_data_out  out  32  forwarded, sign/zero-extended load data.
- mem_addr_out  out  32  address to data memory.
- mem_data_out  out  32  write data to data memory.
- mem_write_out  out  1  memory write enable.
- mem_func3_out  out  3  func3 to data memory.
- count_out  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Entry fields: word address [31:2], byte offset [1:0], func3, data, 4-bit byte mask.
- Byte mask: SB → 1 << addr[1:0]; SH → 0011 or 1100 by addr[1]; SW → 1111.
- Misaligned: SH with addr[0]=1, or SW with addr[1:0]≠0. Such stores are not enqueued; st_misalign_out=1 in the same cycle (combinational).
- Enqueue: st_valid_in && st_ready_out && !st_misalign_out. st_ready_out = (count < DEPTH). There is no same-cycle full bypass.
- Conflict: ld_valid_in, and some valid entry has the same word address with an overlapping byte mask. The load mask is derived the same way (LB/LBU, LH/LHU, LW).
- Port arbitration (combinational), in priority order:
  - ld_valid_in && !conflict: memory port carries the load (addr/func3 from ld_*, mem_write_out=0).
  - Otherwise, if count > 0: port drains the head entry (mem_write_out=1); head pops at the next edge.
  - Otherwise: mem_write_out=0, address/data/func3 = 0.
- ld_stall_out = ld_valid_in && conflict && !forward.
- Simultaneous enqueue and drain: count unchanged; order preserved.
- Circular head/tail pointers wrap modulo DEPTH.

## Timing
- Reset (reset=0 at an edge): count=0 and pointers=0. All buffered stores are discarded, including mid-drain. After reset: st_ready_out=1, mem_write_out=0, ld_stall_out=0, ld_fwd_valid_out=0, ld_fwd_data_out=0.
- A store accepted at edge N can drain at edge N+1 at the earliest (mem_write_out high during cycle N+1 if no load).
- Loads add zero cycles when there is no conflict.
- A conflicting load stays stalled each cycle until every overlapping entry has popped. Stall duration is at most count cycles, because the drain owns the port during a conflict.
- A continuous stream of non-conflicting loads starves draining. This is accepted; the pipeline guarantees bubbles.

## Configuration
- STBUF_FWD_EN defined: if the youngest overlapping entry covers every load byte, forward instead of stalling.
  - Forwarding sets ld_fwd_valid_out=1 and ld_fwd_data_out = extracted, extended bytes.
  - The port still stays with the drain that cycle.
  - Partial coverage still stalls.
- Not defined: every conflict stalls; ld_fwd_valid_out and ld_fwd_data_out are tied to 0.

## Structure
- Shared package `store_buffer_pkg`:
  - func3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - Entry struct typedef.
  - Byte-mask function.
  - Load extract/extend function (shared with the load path).
- One sub-module, `store_buffer_match`: per-entry word/mask compare, youngest-hit select and full-coverage flag.

## Test plan
- SW 0x100=0xDEADBEEF with no loads → cycle after acceptance: mem_write_out=1, mem_addr_out=0x100, mem_data_out=0xDEADBEEF; count returns to 0.
- Fill 4 stores back-to-back while ld_valid_in held with non-conflicting addresses → st_ready_out=0 after 4th, no writes; drop loads → 4 writes in FIFO order.
- SB 0x203=0x80 buffered, LBU 0x200 → no stall (disjoint bytes), load reaches memory same cycle; LB 0x203 → ld_stall_out=1 for 1 cycle (drain), then load passes.
- With STBUF_FWD_EN: SW 0x300=0x1234ABCD buffered, LH 0x302 → ld_fwd_valid_out=1, ld_fwd_data_out=0x00001234, ld_stall_out=0; LW after SB 0x300 → stall.
- SH 0x401 → st_misalign_out=1, count unchanged; SW 0x402 likewise.
- Three stores buffered, reset=0 for one edge during drain → count_out=0, mem_write_out=0 next cycle, no further writes.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the posted-store buffer: func3 codes, entry layout,
// byte-lane masks and load extraction/extension.
package store_buffer_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [29:0] word_addr;
    logic [1:0]  offset;
    logic [2:0]  func3;
    logic [31:0] data;
    logic [3:0]  mask;
  } sb_entry_t;

  // Size comes from func3[1:0]; signedness does not affect which lanes are touched.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      2'b00:   byte_mask = 4'b0001 << offset;
      2'b01:   byte_mask = offset[1] ? 4'b1100 : 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] func3, input logic [1:0] offset,
                                               input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {offset, 3'b000};
    case (func3)
      F3_B:    load_extract = {{24{sh[7]}}, sh[7:0]};
      F3_H:    load_extract = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   load_extract = {24'h0, sh[7:0]};
      F3_HU:   load_extract = {16'h0, sh[15:0]};
      default: load_extract = sh;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Compares a load against every occupied buffer slot; reports any overlap, the
// youngest overlapping slot and whether that slot covers all load bytes.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [29:0]              word_addr [DEPTH],
  input  logic [3:0]               mask      [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic                     ld_valid,
  input  logic [29:0]              ld_word,
  input  logic [3:0]               ld_mask,
  output logic                     conflict,
  output logic [$clog2(DEPTH)-1:0] hit_idx,
  output logic                     full_cover
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] hit;
  logic [PW-1:0]    scan_idx;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    logic [PW-1:0] age;
    // A slot is occupied when its distance from head is below the occupancy count.
    assign age     = PW'(gi) - head;
    assign hit[gi] = ld_valid && ({1'b0, age} < count) &&
                     (word_addr[gi] == ld_word) && ((mask[gi] & ld_mask) != 4'b0000);
  end

  // Scan oldest to youngest so the last hit seen is the youngest.
  always_comb begin
    hit_idx  = head;
    scan_idx = head;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + PW'(k);
      if (hit[scan_idx]) hit_idx = scan_idx;
    end
  end

  assign conflict   = |hit;
  assign full_cover = ((mask[hit_idx] & ld_mask) == ld_mask);

endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO in front of the single data-memory port; loads take priority.
// Define STBUF_FWD_EN to forward loads fully covered by the youngest overlapping store.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid_in,
  input  logic [31:0]            st_addr_in,
  input  logic [31:0]            st_data_in,
  input  logic [2:0]             st_func3_in,
  output logic                   st_ready_out,
  output logic                   st_misalign_out,
  input  logic                   ld_valid_in,
  input  logic [31:0]            ld_addr_in,
  input  logic [2:0]             ld_func3_in,
  output logic                   ld_stall_out,
  output logic                   ld_fwd_valid_out,
  output logic [31:0]            ld_fwd_data_out,
  output logic [31:0]            mem_addr_out,
  output logic [31:0]            mem_data_out,
  output logic                   mem_write_out,
  output logic [2:0]             mem_func3_out,
  output logic [$clog2(DEPTH):0] count_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t     entry_reg [DEPTH];
  logic [PW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg;

  logic [3:0]    st_mask, ld_mask;
  logic          st_bad, enq, ld_go, drain, conflict, full_cover, fwd;
  logic [PW-1:0] hit_idx;
  logic [29:0]   word_addr  [DEPTH];
  logic [3:0]    entry_mask [DEPTH];
  sb_entry_t     head_entry;

  assign st_mask = byte_mask(st_func3_in[1:0], st_addr_in[1:0]);
  assign st_bad  = !(st_func3_in inside {F3_B, F3_H, F3_W}) ||
                   (st_func3_in == F3_H && st_addr_in[0]) ||
                   (st_func3_in == F3_W && st_addr_in[1:0] != 2'b00);
  assign st_misalign_out = st_valid_in && st_bad;
  assign st_ready_out    = count_reg < CW'(DEPTH);
  assign enq             = st_valid_in && st_ready_out && !st_bad;
  assign ld_mask         = byte_mask(ld_func3_in[1:0], ld_addr_in[1:0]);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
    assign word_addr[gi]  = entry_reg[gi].word_addr;
    assign entry_mask[gi] = entry_reg[gi].mask;
  end

  store_buffer_match #(.DEPTH(DEPTH)) u_match (
    .word_addr  (word_addr),
    .mask       (entry_mask),
    .head       (head_reg),
    .count      (count_reg),
    .ld_valid   (ld_valid_in),
    .ld_word    (ld_addr_in[31:2]),
    .ld_mask    (ld_mask),
    .conflict   (conflict),
    .hit_idx    (hit_idx),
    .full_cover (full_cover)
  );

`ifdef STBUF_FWD_EN
  logic [31:0] hit_lane;
  assign hit_lane         = entry_reg[hit_idx].data << {entry_reg[hit_idx].offset, 3'b000};
  assign fwd              = ld_valid_in && conflict && full_cover;
  assign ld_fwd_valid_out = fwd;
  assign ld_fwd_data_out  = fwd ? load_extract(ld_func3_in, ld_addr_in[1:0], hit_lane) : 32'h0;
`else
  logic unused_fwd;
  assign unused_fwd       = &{1'b0, full_cover, hit_idx};
  assign fwd              = 1'b0;
  assign ld_fwd_valid_out = 1'b0;
  assign ld_fwd_data_out  = 32'h0;
`endif

  assign ld_stall_out = ld_valid_in && conflict && !fwd;
  // A conflicting load never takes the port, so the drain can clear the conflict.
  assign ld_go        = ld_valid_in && !conflict;
  assign drain        = !ld_go && (count_reg != '0);
  assign head_entry   = entry_reg[head_reg];
  assign count_out    = count_reg;

  always_comb begin
    mem_addr_out  = 32'h0;
    mem_data_out  = 32'h0;
    mem_func3_out = 3'b000;
    mem_write_out = 1'b0;
    if (ld_go) begin
      mem_addr_out  = ld_addr_in;
      mem_func3_out = ld_func3_in;
    end else if (drain) begin
      mem_addr_out  = {head_entry.word_addr, head_entry.offset};
      mem_data_out  = head_entry.data;
      mem_func3_out = head_entry.func3;
      mem_write_out = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      entry_reg[tail_reg] <= '{word_addr: st_addr_in[31:2], offset: st_addr_in[1:0],
                               func3: st_func3_in, data: st_data_in, mask: st_mask};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (enq)   tail_reg <= tail_reg + PW'(1);
      if (drain) head_reg <= head_reg + PW'(1);
      count_reg <= count_reg + CW'(enq) - CW'(drain);
    end
  end

endmodule
